// File: rtl/lc3_fetch_br.sv
// lc3_fetch_br: LC-3 instruction fetch / decode / branch sequencer.
// Owns the PC and IR. Fetches one word at a time over a ready handshake,
// resolves BR (opcode 0000) locally from the BEN input, and hands all other
// opcodes to the execute stage through Exec_Req / Exec_Done.
//
// Optional feature: define LC3_BR_STATS_EN to add the Br_Taken_Cnt output,
// a saturating count of taken branches. With the macro undefined the port
// and its counter do not exist.
//
// state         | meaning
// S_IDLE        | parked; leaves when Run=1
// S_FETCH_REQ   | drive Mem_Addr=PC, raise Mem_R, clear timeout counter
// S_FETCH_WAIT  | hold request until Mem_Rdy, or fault on timeout
// S_DECODE      | one cycle for BEN to settle on the new IR, then dispatch
// S_BR_EVAL     | apply branch offset when BEN=1
// S_EXEC        | Exec_Req high until the execute stage reports done
// S_HALT        | Halted=1 until Continue
// S_FAULT       | fetch timeout; terminal until reset

module lc3_fetch_br #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Run,
  input  logic        Continue,
  output logic        Mem_R,
  output logic [15:0] Mem_Addr,
  input  logic [15:0] Mem_Data,
  input  logic        Mem_Rdy,
  input  logic        BEN,
  output logic [15:0] IR_out,
  output logic [15:0] PC_out,
  output logic        Exec_Req,
  input  logic        Exec_Done,
  output logic        Halted,
  output logic        Fault
`ifdef LC3_BR_STATS_EN
  ,
  output logic [15:0] Br_Taken_Cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_BR_EVAL,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  // Counter value at which the last allowed wait cycle is being spent.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      boundary;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] br_target;
  logic [7:0]  wait_cnt;

  assign PC_out = pc;
  assign IR_out = ir;

  // Destination at a fetch boundary and the taken-branch target (PC already incremented).
  always_comb begin
    boundary  = Run ? S_FETCH_REQ : S_IDLE;
    br_target = pc + {{7{ir[8]}}, ir[8:0]};
  end

  // Main sequencer: state, PC/IR, memory request and all registered status outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      Mem_Addr <= '0;
      Mem_R    <= 1'b0;
      Exec_Req <= 1'b0;
      Halted   <= 1'b0;
      Fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Run) state <= S_FETCH_REQ;
        end

        S_FETCH_REQ: begin
          Mem_Addr <= pc;
          Mem_R    <= 1'b1;
          wait_cnt <= '0;
          state    <= S_FETCH_WAIT;
        end

        S_FETCH_WAIT: begin
          // Data arriving on the last allowed cycle wins over the timeout.
          if (Mem_Rdy) begin
            ir    <= Mem_Data;
            pc    <= pc + 16'd1;
            Mem_R <= 1'b0;
            state <= S_DECODE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TO_LAST) begin
              Mem_R <= 1'b0;
              Fault <= 1'b1;
              state <= S_FAULT;
            end
          end
        end

        S_DECODE: begin
          case (ir[15:12])
            4'h0: state <= S_BR_EVAL;
            4'hF: begin
              Halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              Exec_Req <= 1'b1;
              state    <= S_EXEC;
            end
          endcase
        end

        S_BR_EVAL: begin
          if (BEN) pc <= br_target;
          state <= boundary;
        end

        S_EXEC: begin
          if (Exec_Done) begin
            Exec_Req <= 1'b0;
            state    <= boundary;
          end
        end

        S_HALT: begin
          // Run is only consulted once Continue releases the halt.
          if (Continue) begin
            Halted <= 1'b0;
            state  <= boundary;
          end
        end

        S_FAULT: begin
          state <= S_FAULT;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LC3_BR_STATS_EN
  // Saturating count of branches resolved as taken.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Br_Taken_Cnt <= '0;
    end else if (state == S_BR_EVAL && BEN && Br_Taken_Cnt != 16'hFFFF) begin
      Br_Taken_Cnt <= Br_Taken_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lc3_fetch_br.sv
// Self-checking bench for lc3_fetch_br. Background responders model the
// memory (configurable or random latency) and the execute stage; BEN is
// produced from IR and a bench-held NZP. A program-level reference model
// predicts the fetch address sequence and final PC.
`timescale 1ns/1ps
module tb_lc3_fetch_br;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Run = 1'b0;
  logic        Continue = 1'b0;
  logic        Mem_R;
  logic [15:0] Mem_Addr;
  logic [15:0] Mem_Data = 16'h0000;
  logic        Mem_Rdy = 1'b0;
  logic        BEN;
  logic [15:0] IR_out;
  logic [15:0] PC_out;
  logic        Exec_Req;
  logic        Exec_Done = 1'b0;
  logic        Halted;
  logic        Fault;
`ifdef LC3_BR_STATS_EN
  logic [15:0] Br_Taken_Cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:65535];
  logic [2:0]  tb_nzp = 3'b000;
  int          mem_lat = 0;
  int          ex_lat = 0;
  logic        mem_en = 1'b1;
  logic        stray_en = 1'b0;
  logic [15:0] fetch_q[$];
  logic [15:0] exp_q[$];
  int          req_t[$];
  int          cyc = 0;
  int          m_cnt = 0;
  int          ex_cnt = 0;
  logic        m_busy = 1'b0;
  logic        ex_busy = 1'b0;

  assign BEN = |(IR_out[11:9] & tb_nzp);

  lc3_fetch_br #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
    .Mem_R(Mem_R), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data), .Mem_Rdy(Mem_Rdy),
    .BEN(BEN), .IR_out(IR_out), .PC_out(PC_out),
    .Exec_Req(Exec_Req), .Exec_Done(Exec_Done), .Halted(Halted), .Fault(Fault)
`ifdef LC3_BR_STATS_EN
    , .Br_Taken_Cnt(Br_Taken_Cnt)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Memory responder: serves mem[] after mem_lat idle cycles (random when negative).
  initial begin
    forever begin
      @(posedge Clk); #1;
      if (!Reset_n || !mem_en) begin
        Mem_Rdy = 1'b0; m_busy = 1'b0;
      end else if (Mem_Rdy) begin
        Mem_Rdy = 1'b0; m_busy = 1'b0;
      end else if (Mem_R) begin
        if (!m_busy) begin
          m_busy = 1'b1;
          m_cnt = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 3));
          req_t.push_back(cyc);
        end
        if (m_cnt == 0) begin
          Mem_Rdy = 1'b1; Mem_Data = mem[Mem_Addr]; fetch_q.push_back(Mem_Addr);
        end else begin
          m_cnt--;
        end
      end
    end
  end

  // Execute-stage responder: Exec_Done after ex_lat cycles; optional stray pulses when idle.
  initial begin
    forever begin
      @(posedge Clk); #1;
      if (!Reset_n) begin
        Exec_Done = 1'b0; ex_busy = 1'b0;
      end else if (Exec_Req) begin
        if (!ex_busy) begin
          ex_busy = 1'b1;
          ex_cnt = (ex_lat >= 0) ? ex_lat : int'($urandom_range(0, 4));
        end
        if (ex_cnt == 0) Exec_Done = 1'b1;
        else begin Exec_Done = 1'b0; ex_cnt--; end
      end else begin
        ex_busy = 1'b0;
        Exec_Done = stray_en && ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    fetch_q.delete(); req_t.delete();
    Reset_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Program-level model: walk n instructions from start_pc using the ISA rules.
  task automatic model_run(input logic [15:0] start_pc, input int n,
                           output logic [15:0] final_pc, output int taken);
    logic [15:0] pc;
    logic [15:0] ir;
    exp_q.delete();
    pc = start_pc; taken = 0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pc);
      ir = mem[pc];
      pc = pc + 16'd1;
      if (ir[15:12] == 4'h0 && (ir[11:9] & tb_nzp) != 3'b000) begin
        pc = pc + {{7{ir[8]}}, ir[8:0]};
        taken++;
      end
      if (ir[15:12] == 4'hF) break;
    end
    final_pc = pc;
  endtask

  // Run from reset until n fetches were served, then drop Run and let the DUT settle.
  task automatic run_program(input int n, output bit ok);
    int budget;
    apply_reset();
    Run = 1'b1;
    budget = n * 40 + 50;
    while (fetch_q.size() < n && budget > 0) begin tick(); budget--; end
    ok = (fetch_q.size() >= n);
    Run = 1'b0;
    repeat (60) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (PC_out !== 16'h0000) begin fails++; $display("FAIL reset_pc: got %h want 0000", PC_out); end
    tests++; if (IR_out !== 16'h0000) begin fails++; $display("FAIL reset_ir: got %h want 0000", IR_out); end
    tests++; if (Mem_Addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h want 0000", Mem_Addr); end
    tests++; if ({Mem_R, Exec_Req, Halted, Fault} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {Mem_R, Exec_Req, Halted, Fault});
    end
`ifdef LC3_BR_STATS_EN
    tests++; if (Br_Taken_Cnt !== 16'h0000) begin fails++; $display("FAIL reset_brcnt: got %h want 0000", Br_Taken_Cnt); end
`endif
  endtask

  task automatic test_exec();
    bit got;
    for (int a = 0; a < 4; a++) mem[a] = 16'h1021;
    mem_en = 1'b1; mem_lat = 2; ex_lat = 3; stray_en = 1'b0;
    apply_reset();
    Run = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin tick(); if (Exec_Req) got = 1'b1; end
    tests++; if (!got) begin fails++; $display("FAIL exec_req_rise: got 0 want 1 within 30 cycles"); end
    tests++; if (IR_out !== 16'h1021) begin fails++; $display("FAIL exec_ir: got %h want 1021", IR_out); end
    tests++; if (PC_out !== 16'h0001) begin fails++; $display("FAIL exec_pc: got %h want 0001", PC_out); end
    for (int k = 0; k < 30 && req_t.size() < 2; k++) tick();
    tests++;
    if (req_t.size() < 2) begin
      fails++; $display("FAIL exec_next_fetch: got %0d requests want 2", req_t.size());
    end else if (req_t[1] - req_t[0] != 9) begin
      fails++; $display("FAIL exec_interval: got %0d cycles want 9", req_t[1] - req_t[0]);
    end
    tests++; if (Mem_Addr !== 16'h0001 || Exec_Req !== 1'b0) begin
      fails++; $display("FAIL exec_next_addr: got addr %h req %b want 0001 0", Mem_Addr, Exec_Req);
    end
    Run = 1'b0;
  endtask

  task automatic test_branch();
    bit ok;
    logic [15:0] fpc;
    int tk;
    for (int v = 0; v < 2; v++) begin
      for (int a = 0; a < 32; a++) mem[a] = 16'h1021;
      mem[5] = 16'h0FFE;
      tb_nzp = (v == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      mem_lat = -1; ex_lat = -1; mem_en = 1'b1; stray_en = 1'b0;
      run_program(8, ok);
      model_run(16'h0000, fetch_q.size(), fpc, tk);
      tests++; if (!ok) begin fails++; $display("FAIL br_progress[%0d]: got %0d fetches want 8", v, fetch_q.size()); end
      if (fetch_q.size() > 6) begin
        tests++; if (fetch_q[6] !== ((v == 0) ? 16'h0004 : 16'h0006)) begin
          fails++; $display("FAIL br_target[%0d]: got %h want %h", v, fetch_q[6], (v == 0) ? 16'h0004 : 16'h0006);
        end
      end
      tests++; if (PC_out !== fpc) begin fails++; $display("FAIL br_final_pc[%0d]: got %h want %h", v, PC_out, fpc); end
    end
    // NOP stream: each not-taken BR costs 4 cycles + memory wait.
    for (int a = 0; a < 16; a++) mem[a] = 16'h0000;
    tb_nzp = 3'b111; mem_lat = 1;
    run_program(4, ok);
    tests++;
    if (req_t.size() < 3) begin fails++; $display("FAIL br_timing: got %0d requests want 3", req_t.size()); end
    else if (req_t[2] - req_t[1] != 5) begin fails++; $display("FAIL br_timing: got %0d cycles want 5", req_t[2] - req_t[1]); end
    tests++; if (PC_out !== 16'(fetch_q.size())) begin fails++; $display("FAIL nop_pc: got %h want %h", PC_out, 16'(fetch_q.size())); end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int a = 0; a < 8; a++) mem[a] = 16'h1021;
    mem[0] = 16'h0FFE;
    mem[16'hFFFF] = 16'h0E01;
    tb_nzp = 3'b111; mem_lat = 0; ex_lat = 0; mem_en = 1'b1;
    run_program(3, ok);
    tests++;
    if (fetch_q.size() < 3) begin fails++; $display("FAIL wrap_progress: got %0d fetches want 3", fetch_q.size()); end
    else if (fetch_q[1] !== 16'hFFFF || fetch_q[2] !== 16'h0001) begin
      fails++; $display("FAIL wrap_addrs: got %h %h want ffff 0001", fetch_q[1], fetch_q[2]);
    end
  endtask

  task automatic test_timeout();
    bit got, hold_ok, quiet_ok;
    mem_en = 1'b0; mem_lat = 0; ex_lat = 0;
    apply_reset();
    Run = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin tick(); if (Mem_R) got = 1'b1; end
    tests++; if (!got) begin fails++; $display("FAIL to_req: got 0 want Mem_R within 10 cycles"); end
    hold_ok = (Fault === 1'b0);
    for (int k = 2; k <= 16; k++) begin tick(); if (Fault !== 1'b0 || Mem_R !== 1'b1) hold_ok = 1'b0; end
    tests++; if (!hold_ok) begin fails++; $display("FAIL to_early: got early fault/drop want 16 wait cycles"); end
    tick();
    tests++; if (Fault !== 1'b1 || Mem_R !== 1'b0) begin
      fails++; $display("FAIL to_fault: got fault %b mem_r %b want 1 0", Fault, Mem_R);
    end
    Continue = 1'b1; mem_en = 1'b1; quiet_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin tick(); if (Fault !== 1'b1 || Mem_R !== 1'b0 || Halted !== 1'b0) quiet_ok = 1'b0; end
    Continue = 1'b0;
    tests++; if (!quiet_ok) begin fails++; $display("FAIL to_sticky: got fault exit want terminal"); end
    // Data on the 16th wait cycle beats the timeout.
    mem[0] = 16'h1021; mem_lat = 15;
    apply_reset();
    Run = 1'b1; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin tick(); if (Exec_Req) got = 1'b1; end
    tests++; if (!got || Fault !== 1'b0 || IR_out !== 16'h1021) begin
      fails++; $display("FAIL to_last_cycle: got req %b fault %b ir %h want 1 0 1021", got, Fault, IR_out);
    end
    Run = 1'b0;
  endtask

  task automatic test_halt();
    bit got, hold_ok;
    mem[0] = 16'hF025; mem[1] = 16'hF025; mem[2] = 16'h1021;
    mem_en = 1'b1; mem_lat = 0; ex_lat = 0;
    apply_reset();
    Run = 1'b1; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin tick(); if (Halted) got = 1'b1; end
    tests++; if (!got || PC_out !== 16'h0001) begin fails++; $display("FAIL halt_enter: got halted %b pc %h want 1 0001", got, PC_out); end
    hold_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin tick(); if (Mem_R !== 1'b0 || Halted !== 1'b1) hold_ok = 1'b0; end
    tests++; if (!hold_ok) begin fails++; $display("FAIL halt_hold: got fetch or release want halted"); end
    Run = 1'b0; Continue = 1'b1;
    tick();
    Continue = 1'b0;
    tests++; if (Halted !== 1'b0) begin fails++; $display("FAIL halt_release: got %b want 0", Halted); end
    hold_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin tick(); if (Mem_R !== 1'b0) hold_ok = 1'b0; end
    tests++; if (!hold_ok) begin fails++; $display("FAIL halt_idle: got Mem_R want idle with Run=0"); end
    Run = 1'b1; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin tick(); if (Halted) got = 1'b1; end
    tests++; if (!got || fetch_q.size() != 2 || PC_out !== 16'h0002) begin
      fails++; $display("FAIL halt_refetch: got %0d fetches pc %h want 2 0002", fetch_q.size(), PC_out);
    end else if (fetch_q[1] !== 16'h0001) begin
      fails++; $display("FAIL halt_refetch_addr: got %h want 0001", fetch_q[1]);
    end
    Continue = 1'b1;
    tick();
    Continue = 1'b0; got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin tick(); if (Mem_R) got = 1'b1; end
    tests++; if (!got || Mem_Addr !== 16'h0002) begin fails++; $display("FAIL halt_continue_run: got %b addr %h want 1 0002", got, Mem_Addr); end
    Run = 1'b0;
  endtask

  task automatic test_async_reset();
    bit got;
    for (int a = 0; a < 16; a++) mem[a] = 16'h0000;
    tb_nzp = 3'b000; mem_en = 1'b1; mem_lat = 0; ex_lat = 0;
    apply_reset();
    Run = 1'b1;
    for (int k = 0; k < 40 && fetch_q.size() < 3; k++) tick();
    for (int k = 0; k < 10 && Mem_R; k++) tick();
    mem_en = 1'b0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin tick(); if (Mem_R) got = 1'b1; end
    tests++; if (!got || PC_out !== 16'(fetch_q.size())) begin
      fails++; $display("FAIL ar_setup: got req %b pc %h want 1 %h", got, PC_out, 16'(fetch_q.size()));
    end
    #2 Reset_n = 1'b0;
    #1;
    tests++; if ({Mem_R, Exec_Req} !== 2'b00 || PC_out !== 16'h0000 || IR_out !== 16'h0000 || Mem_Addr !== 16'h0000) begin
      fails++; $display("FAIL ar_async: got mem_r %b pc %h ir %h addr %h want 0 0000 0000 0000", Mem_R, PC_out, IR_out, Mem_Addr);
    end
    Run = 1'b0;
    tick();
    Reset_n = 1'b1; got = 1'b0;
    for (int k = 0; k < 5; k++) begin tick(); if (Mem_R) got = 1'b1; end
    tests++; if (got) begin fails++; $display("FAIL ar_idle: got Mem_R want idle after release"); end
    fetch_q.delete(); mem_en = 1'b1; Run = 1'b1;
    for (int k = 0; k < 20 && fetch_q.size() < 1; k++) tick();
    tests++; if (fetch_q.size() < 1 || fetch_q[0] !== 16'h0000) begin
      fails++; $display("FAIL ar_restart: got %0d fetches want first addr 0000", fetch_q.size());
    end
    Run = 1'b0;
  endtask

`ifdef LC3_BR_STATS_EN
  task automatic test_stats();
    bit got;
    mem[0] = 16'h0E00; mem[1] = 16'h0E00; mem[2] = 16'h0000; mem[3] = 16'h0E00; mem[4] = 16'hF000;
    tb_nzp = 3'b111; mem_en = 1'b1; mem_lat = 0; ex_lat = 0;
    apply_reset();
    Run = 1'b1; got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin tick(); if (Halted) got = 1'b1; end
    tests++; if (!got || Br_Taken_Cnt !== 16'd3) begin fails++; $display("FAIL stats_count: got %0d want 3", Br_Taken_Cnt); end
    Run = 1'b0;
  endtask
`endif

  task automatic test_random();
    bit ok;
    logic [15:0] fpc;
    int tk;
    logic [3:0] op;
    int unsigned w;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 65536; a++) begin
        w = $urandom;
        op = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 14));
        mem[a] = {op, w[11:0]};
      end
      tb_nzp = 3'($urandom); mem_lat = -1; ex_lat = -1; mem_en = 1'b1; stray_en = 1'b1;
      run_program(40, ok);
      model_run(16'h0000, fetch_q.size(), fpc, tk);
      tests++; if (!ok) begin fails++; $display("FAIL rnd_progress[%0d]: got %0d fetches want 40", it, fetch_q.size()); end
      for (int i = 0; i < fetch_q.size(); i++) begin
        tests++; if (fetch_q[i] !== exp_q[i]) begin fails++; $display("FAIL rnd_addr[%0d.%0d]: got %h want %h", it, i, fetch_q[i], exp_q[i]); end
      end
      tests++; if (PC_out !== fpc || Mem_R !== 1'b0 || Exec_Req !== 1'b0) begin
        fails++; $display("FAIL rnd_final[%0d]: got pc %h mem_r %b req %b want %h 0 0", it, PC_out, Mem_R, Exec_Req, fpc);
      end
`ifdef LC3_BR_STATS_EN
      tests++; if (Br_Taken_Cnt !== 16'(tk)) begin fails++; $display("FAIL rnd_brcnt[%0d]: got %0d want %0d", it, Br_Taken_Cnt, tk); end
`endif
    end
    stray_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exec();
    test_branch();
    test_wrap();
    test_timeout();
    test_halt();
    test_async_reset();
`ifdef LC3_BR_STATS_EN
    test_stats();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lc3_fetch_br.md
Name: lc3_fetch_br

Overview:
Instruction fetch/decode/branch sequencer for the LC-3 datapath. Owns the PC and the IR.
- Fetches words over a ready-handshake memory port and presents IR to the condition-code/BEN stage.
- Consumes the BEN result to resolve BR (opcode 0000) locally.
- Hands every other opcode to the execute stage through a req/done handshake.
- The execute stage, not this block, drives LD_CC into the condition-code stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, max FETCH_WAIT cycles without Mem_Rdy before fault (range 1..255).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  enable fetching; sampled at each fetch boundary.
- Continue  in  1  resume from HALT.
- Mem_R  out  1  read request.
- Mem_Addr  out  16  fetch address (registered).
- Mem_Data  in  16  read data, valid when Mem_Rdy=1.
- Mem_Rdy  in  1  read completes this cycle.
- BEN  in  1  branch-enable from condition-code stage; combinational from IR and stored NZP.
- IR_out  out  16  current instruction register.
- PC_out  out  16  current PC.
- Exec_Req  out  1  non-BR instruction pending for execute stage.
- Exec_Done  in  1  execute stage finished.
- Halted  out  1  in HALT state.
- Fault  out  1  fetch timeout; sticky until reset.

Behaviour:
- Reset_n low, asynchronous: state=IDLE, PC=RESET_PC, IR=0, Mem_Addr=0, Mem_R=0, Exec_Req=0, Halted=0, Fault=0, timeout counter=0. Reset mid-fetch or mid-exec abandons the operation; there is no pending-request memory.
- States: IDLE, FETCH_REQ, FETCH_WAIT, DECODE, BR_EVAL, EXEC, HALT, FAULT.
- Fetch boundary: every transition that would enter FETCH_REQ goes to IDLE instead if Run=0.
- IDLE:
  - Run=1 -> FETCH_REQ.
- FETCH_REQ, 1 cycle:
  - Mem_Addr<=PC, Mem_R<=1, counter<=0.
  - -> FETCH_WAIT.
- FETCH_WAIT:
  - Mem_R held 1 and Mem_Addr stable.
  - On Mem_Rdy=1: IR<=Mem_Data, PC<=PC+1 (mod 2^16), Mem_R<=0, -> DECODE.
  - Else counter+1. When the counter reaches TIMEOUT_CYCLES: Mem_R<=0, Fault<=1, -> FAULT.
  - Mem_Rdy in the same cycle as the last allowed count takes priority over the timeout.
- DECODE, 1 cycle, gives BEN a cycle to settle on the new IR:
  - IR[15:12]=0000 -> BR_EVAL.
  - IR[15:12]=1111 -> HALT.
  - Else -> EXEC, with Exec_Req<=1.
- BR_EVAL, 1 cycle:
  - If BEN=1: PC<=PC+sext(IR[8:0]), 16-bit wrap, PC here is already incremented.
  - BEN=0 leaves PC unchanged. NOP (IR=16'h0000) gives BEN=0, so it is not taken.
  - -> fetch boundary.
- EXEC:
  - Exec_Req=1 until a cycle with Exec_Done=1; Exec_Req<=0 on that edge.
  - -> fetch boundary. Minimum EXEC residency is 1 cycle.
  - Exec_Done outside EXEC is ignored.
- HALT:
  - Halted=1.
  - Continue=1 -> Halted<=0, then fetch boundary.
  - Run is not checked until Continue.
- FAULT: terminal; exits only via Reset_n.
- Throughput: BR = 4 cycles + memory wait; other ops = 3 + wait + exec cycles.

Optional Feature:
- Macro: LC3_BR_STATS_EN.
- Defined: adds output Br_Taken_Cnt[15:0]. Resets to 0. Increments on each BR_EVAL with BEN=1. Saturates at 16'hFFFF.
- Undefined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset_n low during FETCH_WAIT with Mem_R=1 -> Mem_R=0 immediately (async), PC=RESET_PC=0x0000, IR=0, state IDLE after release.
- Run=1, memory at 0x0000=16'h1021 with Mem_Rdy after 2 wait cycles -> IR=0x1021, PC=0x0001, Exec_Req high; Exec_Done after 3 cycles -> Exec_Req low, next Mem_Addr=0x0001.
- IR=16'h0FFE (BRnzp -2) fetched at 0x0005, BEN=1 -> PC=0x0006-2=0x0004; same word with BEN=0 -> PC=0x0006.
- RESET_PC=16'hFFFF, BR offset +1 taken -> PC wraps 0xFFFF->0x0000->0x0001.
- Mem_Rdy never asserted, TIMEOUT_CYCLES=16 -> Fault=1 and Mem_R=0 after 16 FETCH_WAIT cycles; Continue/Run ignored; Mem_Rdy on cycle 16 instead -> no fault.
- IR=16'hF025 -> Halted=1, no Mem_R; Continue pulse with Run=0 -> IDLE; with Run=1 -> Mem_Addr=PC next fetch; with LC3_BR_STATS_EN, 3 taken BRs -> Br_Taken_Cnt=3.
